// File: rtl/cpu_control_fsm.sv
// Multi-cycle control unit for the 16-bit CPU.
// Fetches over a req/ready handshake, decodes, and steps the register file
// and the clocked ALU through fixed states. The current state number is
// exported on fsm so the ALU and any checker can follow the sequence.
//
// Fetch handshake: imem_req is high for every FETCH cycle and imem_addr = pc.
// The fetch completes on the first cycle with imem_req && imem_ready; only
// then are imem_rdata captured and pc advanced. imem_rdata is ignored
// otherwise. Reset abandons any fetch in flight.
module cpu_control_fsm #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic [15:0] imem_rdata,
    output logic [3:0]  fsm,
    output logic [3:0]  alu_codop,
    output logic        alu_b_imm,
    output logic [15:0] imm,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    input  logic        alu_neg,
    input  logic        alu_zero,
    input  logic        alu_overflow,
    output logic        flag_z,
    output logic        flag_n,
    output logic        flag_v,
    output logic [15:0] pc,
    output logic        halted,
    output logic        illegal
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_READ      = 4'd2;
    localparam logic [3:0] S_BRANCH    = 4'd3;
    localparam logic [3:0] S_EXECUTE   = 4'd4;
    localparam logic [3:0] S_WRITEBACK = 4'd5;
    localparam logic [3:0] S_HALT      = 4'd6;

    localparam logic [3:0] OP_JMP  = 4'd11;
    localparam logic [3:0] OP_BEQZ = 4'd12;
    localparam logic [3:0] OP_HLT  = 4'd15;

    logic [3:0]  state;
    logic [15:0] ir;
    logic [3:0]  op;
    logic        is_alu_op;
    logic        is_i_type;
    logic [15:0] branch_off;

    assign op         = ir[15:12];
    assign is_alu_op  = (op <= 4'd10);
    assign is_i_type  = (op >= 4'd6) && (op <= 4'd10);
    assign branch_off = {{8{ir[7]}}, ir[7:0]};

    // Outputs decoded from registered state and ir only.
    assign fsm        = state;
    assign imem_req   = (state == S_FETCH);
    assign imem_addr  = pc;
    assign alu_codop  = is_alu_op ? op : 4'd15;
    assign alu_b_imm  = is_i_type;
    assign imm        = {8'h00, ir[7:0]};
    assign rf_raddr_a = is_i_type ? ir[11:8] : ir[7:4];
    assign rf_raddr_b = ir[3:0];
    assign rf_we      = (state == S_WRITEBACK);
    assign rf_waddr   = ir[11:8];
    assign halted     = (state == S_HALT);

    // State sequencing, instruction capture, pc update and flag latching.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            pc      <= PC_RESET;
            ir      <= 16'h0000;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (imem_ready) begin
                        ir    <= imem_rdata;
                        pc    <= pc + 16'd1;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (is_alu_op) begin
                        state <= S_READ;
                    end else if (op == OP_JMP || op == OP_BEQZ) begin
                        state <= S_BRANCH;
                    end else if (op == OP_HLT) begin
                        state <= S_HALT;
                    end else begin
                        // Opcodes 13/14: flag and carry on as a NOP.
                        illegal <= 1'b1;
                        state   <= S_FETCH;
                    end
                end
                S_READ:    state <= S_EXECUTE;
                S_EXECUTE: state <= S_WRITEBACK;
                S_WRITEBACK: begin
                    flag_z <= alu_zero;
                    flag_n <= alu_neg;
                    flag_v <= alu_overflow;
                    state  <= S_FETCH;
                end
                S_BRANCH: begin
                    // pc already points past the branch, so offsets are from pc+1.
                    if (op == OP_JMP) begin
                        pc <= {4'h0, ir[11:0]};
                    end else if (flag_z) begin
                        pc <= pc + branch_off;
                    end
                    state <= S_FETCH;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed bench for cpu_control_fsm: a flat instruction memory, hand-computed
// state sequences, pc values and flag results for each scenario.
module tb_cpu_control_fsm;

    // ---------------- clock / reset ----------------
    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ready;
    logic [15:0] imem_rdata;
    logic [3:0]  fsm;
    logic [3:0]  alu_codop;
    logic        alu_b_imm;
    logic [15:0] imm;
    logic [3:0]  rf_raddr_a;
    logic [3:0]  rf_raddr_b;
    logic        rf_we;
    logic [3:0]  rf_waddr;
    logic        alu_neg;
    logic        alu_zero;
    logic        alu_overflow;
    logic        flag_z;
    logic        flag_n;
    logic        flag_v;
    logic [15:0] pc;
    logic        halted;
    logic        illegal;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cpu_control_fsm #(.PC_RESET(16'h0000)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .fsm          (fsm),
        .alu_codop    (alu_codop),
        .alu_b_imm    (alu_b_imm),
        .imm          (imm),
        .rf_raddr_a   (rf_raddr_a),
        .rf_raddr_b   (rf_raddr_b),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .alu_neg      (alu_neg),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .flag_z       (flag_z),
        .flag_n       (flag_n),
        .flag_v       (flag_v),
        .pc           (pc),
        .halted       (halted),
        .illegal      (illegal)
    );

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // One clock: present memory data for the current address, take the edge,
    // then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(negedge clk);
        imem_rdata = mem[imem_addr];
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    logic [3:0] seq [0:4];
    int n;
    logic we_seen;

    initial begin
        rst_n        = 1'b0;
        imem_ready   = 1'b0;
        imem_rdata   = 16'h0000;
        alu_neg      = 1'b0;
        alu_zero     = 1'b0;
        alu_overflow = 1'b0;
        for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
        seq[0] = 4'd0; seq[1] = 4'd1; seq[2] = 4'd2; seq[3] = 4'd4; seq[4] = 4'd5;

        // 1: addi r1,5 ; add r2,r1,r1 with zero-wait memory
        mem[0] = 16'h9105;
        mem[1] = 16'h0211;
        imem_ready = 1'b1;
        do_reset();
        check("rst_fsm", {12'h0, fsm}, 16'd0);
        check("rst_pc", pc, 16'h0000);
        check("rst_we", {15'h0, rf_we}, 16'd0);
        check("rst_req", {15'h0, imem_req}, 16'd1);
        check("rst_flags", {13'h0, flag_z, flag_n, flag_v}, 16'd0);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("seq_fsm%0d", i), {12'h0, fsm}, {12'h0, seq[i % 5]});
            check($sformatf("seq_we%0d", i), {15'h0, rf_we}, (i % 5 == 4) ? 16'd1 : 16'd0);
            if (i == 0) check("fetch_addr0", imem_addr, 16'h0000);
            if (i == 3) begin
                check("addi_codop", {12'h0, alu_codop}, 16'd9);
                check("addi_bimm", {15'h0, alu_b_imm}, 16'd1);
                check("addi_imm", imm, 16'h0005);
                check("addi_ra", {12'h0, rf_raddr_a}, 16'd1);
            end
            if (i == 4) check("addi_waddr", {12'h0, rf_waddr}, 16'd1);
            if (i == 8) begin
                check("add_codop", {12'h0, alu_codop}, 16'd0);
                check("add_bimm", {15'h0, alu_b_imm}, 16'd0);
                check("add_ra", {12'h0, rf_raddr_a}, 16'd1);
                check("add_rb", {12'h0, rf_raddr_b}, 16'd1);
            end
            if (i == 9) check("add_waddr", {12'h0, rf_waddr}, 16'd2);
            tick();
        end

        // 2: three FETCH wait cycles
        mem[0] = 16'h9105;
        do_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("wait_fsm", {12'h0, fsm}, 16'd0);
            check("wait_req", {15'h0, imem_req}, 16'd1);
            check("wait_pc", pc, 16'h0000);
            tick();
        end
        check("wait_fsm_end", {12'h0, fsm}, 16'd0);
        imem_ready = 1'b1;
        n = 0;
        while (!rf_we && n < 20) begin
            tick();
            n++;
        end
        check("wait_latency", n[15:0], 16'd4);

        // 3: JMP 0x010 ; subi -> zero ; BEQZ -2 taken, then not taken
        mem[0]  = 16'hB010;
        mem[16] = 16'hA101;
        mem[17] = 16'hC0FE;
        alu_zero = 1'b1;
        do_reset();
        repeat (3) tick();
        check("jmp10_pc", pc, 16'h0010);
        check("jmp10_fsm", {12'h0, fsm}, 16'd0);
        repeat (5) tick();
        check("subi_z", {15'h0, flag_z}, 16'd1);
        check("subi_pc", pc, 16'h0011);
        repeat (2) tick();
        check("beqz_fsm", {12'h0, fsm}, 16'd3);
        check("beqz_codop", {12'h0, alu_codop}, 16'd15);
        tick();
        check("beqz_taken_pc", pc, 16'h0010);
        check("beqz_keeps_z", {15'h0, flag_z}, 16'd1);
        alu_zero = 1'b0;
        alu_neg  = 1'b1;
        repeat (5) tick();
        check("subi2_flags", {13'h0, flag_z, flag_n, flag_v}, 16'b010);
        repeat (3) tick();
        check("beqz_nt_pc", pc, 16'h0012);
        check("beqz_keeps_n", {15'h0, flag_n}, 16'd1);
        alu_neg = 1'b0;

        // 4: reach 0xFFFF via BEQZ, then JMP 0xBABC with pc wrap
        mem[0]      = 16'hA000;
        mem[1]      = 16'hC0FD;
        mem[16'hFFFF] = 16'hBABC;
        alu_zero = 1'b1;
        do_reset();
        repeat (5) tick();
        alu_zero = 1'b0;
        check("pre_z", {15'h0, flag_z}, 16'd1);
        repeat (3) tick();
        check("back_pc", pc, 16'hFFFF);
        check("back_addr", imem_addr, 16'hFFFF);
        we_seen = rf_we;
        tick();
        check("wrap_pc", pc, 16'h0000);
        we_seen = we_seen | rf_we;
        tick();
        we_seen = we_seen | rf_we;
        tick();
        check("jmp_pc", pc, 16'h0ABC);
        check("jmp_no_we", {15'h0, we_seen}, 16'd0);

        // 5: illegal opcode 13, then HLT, then reset out of HALT
        mem[0] = 16'hD000;
        mem[1] = 16'hF000;
        do_reset();
        tick();
        check("ill_dec_we", {15'h0, rf_we}, 16'd0);
        tick();
        check("ill_flag", {15'h0, illegal}, 16'd1);
        check("ill_fsm", {12'h0, fsm}, 16'd0);
        check("ill_pc", pc, 16'h0001);
        repeat (2) tick();
        for (int i = 0; i < 20; i++) begin
            check("hlt_fsm", {12'h0, fsm}, 16'd6);
            check("hlt_halted", {15'h0, halted}, 16'd1);
            check("hlt_req", {15'h0, imem_req}, 16'd0);
            check("hlt_we", {15'h0, rf_we}, 16'd0);
            tick();
        end
        rst_n = 1'b0;
        tick();
        check("hrst_pc", pc, 16'h0000);
        check("hrst_fsm", {12'h0, fsm}, 16'd0);
        check("hrst_halted", {15'h0, halted}, 16'd0);
        check("hrst_illegal", {15'h0, illegal}, 16'd0);
        rst_n = 1'b1;

        // 6: set all flags, then reset during a FETCH wait with a late ready
        mem[0] = 16'h9105;
        do_reset();
        alu_zero     = 1'b1;
        alu_neg      = 1'b1;
        alu_overflow = 1'b1;
        repeat (5) tick();
        check("set_flags", {13'h0, flag_z, flag_n, flag_v}, 16'b111);
        imem_ready = 1'b0;
        repeat (2) tick();
        check("fw_fsm", {12'h0, fsm}, 16'd0);
        check("fw_pc", pc, 16'h0001);
        rst_n      = 1'b0;
        imem_ready = 1'b1;
        tick();
        check("frst_pc", pc, 16'h0000);
        check("frst_fsm", {12'h0, fsm}, 16'd0);
        check("frst_flags", {13'h0, flag_z, flag_n, flag_v}, 16'd0);
        check("frst_ir", {12'h0, alu_codop}, 16'd0);
        check("frst_imm", imm, 16'h0000);
        rst_n = 1'b1;
        check("frst_req", {15'h0, imem_req}, 16'd1);

        // ---------------- report ----------------
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cpu_control_fsm.md
Name: cpu_control_fsm

Overview:
Multi-cycle control unit for the 16-bit CPU. It fetches instructions over a ready/req handshake, decodes them, and sequences the register file and the 4-bit-codop ALU through fixed states. The ALU is clocked and captures its result on the clk edge that ends state 4 (EXECUTE). This block drives that state number, the ALU codop, operand selects, register writeback, PC update and flag latching.

Parameters:
PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
clk  in  1  system clock, all logic on posedge
rst_n  in  1  synchronous active-low reset
imem_req  out  1  instruction fetch request
imem_addr  out  16  fetch address (= pc)
imem_ready  in  1  fetch data valid this cycle
imem_rdata  in  16  fetched instruction
fsm  out  4  current state code, wired to ALU fsm input
alu_codop  out  4  ALU operation code
alu_b_imm  out  1  1: ALU b operand = imm (zero-extended ir[7:0]); 0: b = rf port B
imm  out  16  {8'h00, ir[7:0]}
rf_raddr_a  out  4  register read address A
rf_raddr_b  out  4  register read address B
rf_we  out  1  register write enable
rf_waddr  out  4  register write address
alu_neg, alu_zero, alu_overflow  in  1 each  ALU flags (combinational from ALU out)
flag_z, flag_n, flag_v  out  1 each  latched flags
pc  out  16  program counter
halted  out  1  CPU stopped
illegal  out  1  sticky illegal-opcode indicator

Behaviour:
- Instruction formats: R = op[15:12] rd[11:8] rs[7:4] rt[3:0]; I = op rd imm8[7:0].
- Opcodes 0-5 (add, sub, slti, and, or, xor): R-type. a = rf[rs], b = rf[rt], alu_b_imm = 0.
- Opcodes 6-10 (andi, ori, xori, addi, subi): I-type, two-address. a = rf[rd], b = imm, alu_b_imm = 1.
- Opcode 11 JMP: pc <= {4'h0, ir[11:0]}.
- Opcode 12 BEQZ: if flag_z, pc <= pc + sign_extend(imm8), modulo 2^16.
- Opcode 15 HLT.
- Opcodes 13 and 14: illegal. Set illegal = 1 and execute as NOP.
- alu_codop = ir[15:12] for opcodes 0-10; 4'd15 otherwise, which makes the ALU output 0.
- State codes:
  - 0 FETCH
  - 1 DECODE
  - 2 READ
  - 3 BRANCH
  - 4 EXECUTE
  - 5 WRITEBACK
  - 6 HALT
- FETCH: imem_req = 1, imem_addr = pc. Hold until imem_ready. On the ready cycle: ir <= imem_rdata, pc <= pc+1 (16'hFFFF wraps to 0), go to DECODE. imem_rdata is ignored when imem_ready = 0.
- DECODE transitions:
  - 0-10: to READ.
  - 11 or 12: to BRANCH.
  - 15: to HALT.
  - 13 or 14: illegal <= 1, to FETCH.
- READ: rf_raddr_a/b are driven from ir (valid from DECODE onward). Go to EXECUTE.
- EXECUTE (fsm = 4): alu_codop is stable. The ALU registers its result at the end of this cycle. Go to WRITEBACK.
- WRITEBACK:
  - rf_we = 1 for exactly one cycle, rf_waddr = rd.
  - flag_z/n/v <= alu_zero/neg/overflow, sampled this cycle.
  - Go to FETCH.
- BRANCH: update pc per opcode (BEQZ not-taken leaves pc unchanged). Go to FETCH. Flags are not modified.
- HALT: stay forever. halted = 1, imem_req = 0, rf_we = 0. Only reset exits.
- Latency with zero-wait memory (imem_ready already high in FETCH): ALU op = 5 cycles, JMP/BEQZ = 3 cycles. Each FETCH wait cycle adds 1.
- rf_we is 0 in every state except WRITEBACK. imem_req is 1 only in FETCH.
- Reset (checked every edge, overrides all states, including mid-fetch and HALT):
  - fsm = 0, pc = PC_RESET, ir = 16'h0000.
  - flags = 0, halted = 0, illegal = 0.
  - rf_we = 0.
  - imem_req = 1 on the first cycle after reset release.
- A fetch in progress when reset is asserted is abandoned. A late imem_ready is ignored while rst_n = 0.
- All outputs are registered or decoded from registered state and ir only. There is no combinational path from input to output except none.

Test Plan:
- Reset, imem_ready = 1, program {16'h9105 addi r1,5 ; 16'h0211 add r2,r1,r1} -> fsm sequence 0,1,2,4,5 twice. rf_we pulses at cycles 5 and 10. rf_waddr = 1 then 2. Op 2: alu_codop = 0, alu_b_imm = 0, rf_raddr_a/b = 1/1.
- imem_ready held low 3 cycles in FETCH -> fsm stays 0, imem_req = 1, pc unchanged. The instruction completes 3 cycles later than the zero-wait case.
- subi producing zero (alu_zero = 1 in WRITEBACK), then BEQZ imm8 = 8'hFE at pc = 16'h0011 (pc+1 = 16'h0012) -> pc = 16'h0010. Repeat with flag_z = 0 -> pc = 16'h0012.
- JMP 16'hBABC at pc = 16'hFFFF -> fetch wraps pc to 0, then pc = 16'h0ABC. rf_we never asserts.
- Opcode 13 -> illegal = 1, no rf_we, next fetch at pc+1. Then HLT -> fsm = 6, halted = 1, imem_req = 0 for 20 cycles.
- rst_n low during FETCH wait and again during HALT -> next edge: pc = 0, fsm = 0, halted = 0, illegal = 0, flags = 0.
